// File: rtl/clap_pkg.sv
// rtl/clap_pkg.sv - shared state encoding and default sizing for clap blocks
package clap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH    = 17;
  localparam int DEF_MAXCOUNT = 66080;
  localparam int DEF_WRAPW    = 8;

endpackage

// File: rtl/clap_timer_if.sv
// rtl/clap_timer_if.sv - control inputs and status outputs of the clap timer
interface clap_timer_if import clap_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WRAPW = DEF_WRAPW
);
  logic             go;
  logic             en;
  logic             hold;
  logic             clap;
  logic             wrap_mode;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] lap;
  logic             lap_valid;
  logic             done;
  logic             busy;
  logic [WRAPW-1:0] wraps;

  modport master (
    output go, en, hold, clap, wrap_mode,
    input  count, lap, lap_valid, done, busy, wraps
  );

  modport slave (
    input  go, en, hold, clap, wrap_mode,
    output count, lap, lap_valid, done, busy, wraps
  );
endinterface

// File: rtl/clap_edge_detect.sv
// rtl/clap_edge_detect.sv - registered rising-edge detector for a synchronous level
module clap_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic din_q;
  logic din_d;

  always_comb begin
    din_d = din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) din_q <= 1'b0;
    else       din_q <= din_d;
  end

  assign rise = din & ~din_q;
endmodule

// File: rtl/clap_timer.sv
// rtl/clap_timer.sv - tick-driven interval timer with one-shot/wrap modes and lap capture
module clap_timer import clap_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAXCOUNT = DEF_MAXCOUNT,
  parameter int WRAPW    = DEF_WRAPW
) (
  input  logic         clk,
  input  logic         reset,
  clap_timer_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAXCOUNT);
  localparam logic [WRAPW-1:0] WRAP_SAT = {WRAPW{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lap_q, lap_d;
  logic             lap_valid_q, lap_valid_d;
  logic             done_q, done_d;
  logic [WRAPW-1:0] wraps_q, wraps_d;
  logic             clap_rise;

  clap_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.clap),
    .rise  (clap_rise)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lap_d       = lap_q;
    lap_valid_d = 1'b0;
    done_d      = 1'b0;
    wraps_d     = wraps_q;

    if (bus.go) begin
      state_d = ST_COUNT;
      count_d = '0;
      wraps_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: count_d = '0;
        ST_COUNT: begin
          // lap takes the pre-increment count
          if (clap_rise) begin
            lap_d       = count_q;
            lap_valid_d = 1'b1;
          end
          if (bus.hold) begin
            state_d = ST_HOLD;
          end else if (bus.en) begin
            if (count_q == MAX_C) begin
              if (bus.wrap_mode) begin
                count_d = '0;
                if (wraps_q != WRAP_SAT) wraps_d = wraps_q + WRAPW'(1);
              end else begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (clap_rise) begin
            lap_d       = count_q;
            lap_valid_d = 1'b1;
          end
          if (!bus.hold) state_d = ST_COUNT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      done_q      <= 1'b0;
      wraps_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lap_q       <= lap_d;
      lap_valid_q <= lap_valid_d;
      done_q      <= done_d;
      wraps_q     <= wraps_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.lap       = lap_q;
  assign bus.lap_valid = lap_valid_q;
  assign bus.done      = done_q;
  assign bus.wraps     = wraps_q;
  assign bus.busy      = (state_q == ST_COUNT) || (state_q == ST_HOLD);
endmodule
